alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle ALU for the CPU datapath. It adds the following to the existing single-cycle operation set:
- registered results with a valid/ready handshake on both sides;
- variable-distance shifts and rotates;
- arithmetic flags;
- an optional iterative multiplier.

It sits between the register-file read stage and write-back; the controller stalls issue while `in_ready` is low.

## Interface
- `WIDTH`, 8: datapath width in bits, ≥4, power of two.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  `e_alu_op`  operation: CPY, ADD, SUB, AND, OR, XOR, GT, EXT, MUL.
- `exop`  in  `e_alu_ext_op`  EXT sub-op: SHFL, SHFR, ROTR, ASHR.
- `srcA`  in  WIDTH  operand A, shift source, multiplicand.
- `srcB`  in  WIDTH  operand B; shift distance k = `srcB[$clog2(WIDTH)-1:0]`; multiplier.
- `in_valid`  in  1  operands and op valid.
- `in_ready`  out  1  block can accept an operation.
- `result`  out  WIDTH  result, or low product word.
- `result_hi`  out  WIDTH  high product word; 0 for non-MUL.
- `zero`, `carry`, `negative`, `overflow`  out  1 each  flags.
- `out_valid`  out  1  result/flags valid.
- `out_ready`  in  1  consumer takes result.

## Operation
- FSM states are IDLE, SHIFT, MUL, DONE. On reset: state IDLE, `in_ready`=1, `out_valid`=0, all data and flag outputs 0.
- Accept happens when `in_valid && in_ready`, which is only possible in IDLE. On accept, op/exop/operands are latched; later changes on the inputs are ignored.
- Single-step ops (CPY, ADD, SUB, AND, OR, XOR, GT, EXT with k=0, unsupported codes) compute directly into the output register. The FSM goes IDLE→DONE.
  - Unsupported codes produce result 0.
  - EXT with unknown exop passes srcA through.
- EXT with k>0 goes IDLE→SHIFT. Each SHIFT cycle moves one bit and decrements the counter; the FSM goes to DONE when the counter reaches 0.
  - SHFL: zero fill at LSB.
  - SHFR: zero fill at MSB.
  - ASHR: MSB replicated.
  - ROTR: bit 0 moves to the MSB.
- MUL goes IDLE→MUL for exactly WIDTH cycles of unsigned shift-add on a 2·WIDTH accumulator, then DONE. `{result_hi,result}` = srcA·srcB.
- DONE: `out_valid`=1 and outputs are held stable until `out_ready`=1, then the FSM goes to IDLE. There is no accept in the same cycle as DONE→IDLE.
- Arithmetic is modulo 2^WIDTH. GT is an unsigned compare giving 1 or 0.
- Flags:
  - `zero` = (result==0), low word only.
  - `negative` = result[WIDTH-1].
  - `carry`: carry-out for ADD; borrow (srcA<srcB) for SUB; last bit shifted out for SHFL/SHFR/ASHR/ROTR with k>0; (result_hi≠0) for MUL; 0 otherwise.
  - `overflow`: two's-complement overflow for ADD/SUB; 0 otherwise.
- Reset asserted mid-operation aborts immediately and all outputs return to their reset values.

## Timing
- Accept at edge N:
  - single-step ops: `out_valid` high after edge N+1;
  - shifts: after edge N+1+k;
  - MUL: after edge N+1+WIDTH.
- `in_ready` falls after the accept edge and rises after the edge on which `out_valid && out_ready` is sampled.
- Peak throughput is one single-step op per 2 cycles.
- Output stability: `out_valid`, `result`, `result_hi` and the flags do not change while `out_valid && !out_ready`.

## Configuration
- `ALU_MUL_EN` defined: the MUL state, multiplier counter and accumulator are compiled in.
- `ALU_MUL_EN` undefined: ALU_MUL is treated as an unsupported code. It is single-step with result 0, `result_hi` 0 and all flags 0 except zero=1. `result_hi` is tied to 0.

## Structure
- The shared package `project_pkg` holds:
  - `e_alu_op`, extended with ALU_MUL;
  - `e_alu_ext_op`, extended with AEX_ASHR;
  - the FSM state enum `e_alu_seq_state`;
  - a `alu_flags_t` struct {zero, carry, negative, overflow}.
- Sub-module `alu_flags` (combinational): takes op, exop, operands, result, result_hi and the last shifted-out bit, and returns `alu_flags_t`.

## Test plan
- ADD 200+100, WIDTH=8 → result 44, carry=1, overflow=0, negative=0; `out_valid` one cycle after accept.
- SUB 100−120 → result 236, carry=1, negative=1, overflow=0. SUB 127−(−1)=127−255 → result 128, overflow=1.
- EXT SHFL 0x96, k=3 → result 0xB0, carry=0, `out_valid` 4 cycles after accept. ASHR 0x80, k=7 → 0xFF. ROTR 0x01, k=1 → 0x80, carry=1.
- MUL (`ALU_MUL_EN`) 200×3 → result 0x58, `result_hi` 0x02, carry=1 after 9 cycles. 15×17 → 255, hi 0, carry=0. Without the macro → result 0, zero=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after a result → outputs stable, `in_ready`=0, a new `in_valid` is ignored. Release → next op accepted the following cycle.
- Reset mid-MUL (cycle 4) → all outputs 0 and `in_ready`=1 immediately. The next ADD 1+1 returns 2.

Source files
------------

// File: rtl/project_pkg.sv
// Shared ALU types: op codes, EXT sub-ops, sequencer states and the flag bundle.
// The MUL op code is always present; its datapath exists only when ALU_MUL_EN is defined.
package project_pkg;

  // Encodings 9..15 are unsupported and produce a zero result.
  typedef enum logic [3:0] {
    ALU_CPY = 4'd0, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_GT, ALU_EXT, ALU_MUL
  } e_alu_op;

  // Encodings 4..7 are unknown sub-ops; EXT passes srcA through for them.
  typedef enum logic [2:0] {
    AEX_SHFL = 3'd0, AEX_SHFR, AEX_ROTR, AEX_ASHR
  } e_alu_ext_op;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} e_alu_seq_state;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } alu_flags_t;

  // True for the sub-ops that move bits; only these take the iterative path.
  function automatic logic is_shift_op(e_alu_ext_op x);
    return (x == AEX_SHFL) || (x == AEX_SHFR) || (x == AEX_ROTR) || (x == AEX_ASHR);
  endfunction

endpackage

// File: rtl/alu_flags.sv
// Combinational flag generation from the operation, its operands and its final result.
module alu_flags
  import project_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  e_alu_op             op,
  input  e_alu_ext_op         exop,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    result,
  input  logic [WIDTH-1:0]    result_hi,
  input  logic                shout,
  output alu_flags_t          flags
);
  localparam int KW = $clog2(WIDTH);

  logic [WIDTH:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  // zero/negative always track the low word; carry/overflow depend on the op.
  always_comb begin
    flags          = '0;
    flags.zero     = (result == '0);
    flags.negative = result[WIDTH-1];
    case (op)
      ALU_ADD: begin
        flags.carry    = sum[WIDTH];
        flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        flags.carry    = (a < b);
        flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_EXT: flags.carry = (b[KW-1:0] != '0) && is_shift_op(exop) && shout;
      ALU_MUL: flags.carry = (result_hi != '0);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes, bit-serial shifts/rotates and flags.
// Define ALU_MUL_EN to compile in the iterative shift-add multiplier; without it
// ALU_MUL behaves as an unsupported code and result_hi is tied to zero.
module alu_seq
  import project_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  e_alu_op          op,
  input  e_alu_ext_op      exop,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int KW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  e_alu_seq_state   state, nstate;
  e_alu_op          op_r;
  e_alu_ext_op      exop_r;
  logic [WIDTH-1:0] a_r, b_r, sh_r, res_r;
  logic [CW-1:0]    cnt;
  alu_flags_t       flags_r, flags_nx;

  logic             accept, shift_go, load, step_bit, f_sh;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] ss_res, step_val, res_nx, hi_nx, f_a, f_b;
  e_alu_op          f_op;
  e_alu_ext_op      f_exop;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign k         = srcB[KW-1:0];
  assign shift_go  = (op == ALU_EXT) && (k != '0) && is_shift_op(exop);
  assign result    = res_r;
  assign {zero, carry, negative, overflow} = flags_r;

  // Single-step result straight from the live operands.
  always_comb begin
    ss_res = '0;
    case (op)
      ALU_CPY: ss_res = srcA;
      ALU_ADD: ss_res = srcA + srcB;
      ALU_SUB: ss_res = srcA - srcB;
      ALU_AND: ss_res = srcA & srcB;
      ALU_OR:  ss_res = srcA | srcB;
      ALU_XOR: ss_res = srcA ^ srcB;
      ALU_GT:  ss_res = {{(WIDTH-1){1'b0}}, srcA > srcB};
      ALU_EXT: ss_res = srcA;
      default: ss_res = '0;
    endcase
  end

  // One bit of shift/rotate per cycle; step_bit is the bit that leaves the word.
  always_comb begin
    step_val = sh_r;
    step_bit = 1'b0;
    case (exop_r)
      AEX_SHFL: begin step_val = {sh_r[WIDTH-2:0], 1'b0};     step_bit = sh_r[WIDTH-1]; end
      AEX_SHFR: begin step_val = {1'b0, sh_r[WIDTH-1:1]};     step_bit = sh_r[0];       end
      AEX_ROTR: begin step_val = {sh_r[0], sh_r[WIDTH-1:1]};  step_bit = sh_r[0];       end
      AEX_ASHR: begin step_val = {sh_r[WIDTH-1], sh_r[WIDTH-1:1]}; step_bit = sh_r[0]; end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH:0]     mul_sum;

  // Shift-add: conditionally add the multiplicand to the upper half, then shift right.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_r} : '0);
  assign acc_nx    = {mul_sum, acc[WIDTH-1:1]};
  assign result_hi = hi_r;

  // Accumulator seeds with the multiplier in the low half and shifts once per MUL cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      hi_r <= '0;
    end else begin
      if (accept)              acc  <= {{WIDTH{1'b0}}, srcB};
      else if (state == MUL)   acc  <= acc_nx;
      if (load)                hi_r <= hi_nx;
    end
  end
`else
  assign result_hi = '0;
`endif

  // Next state plus the value to be captured into the output registers.
  always_comb begin
    nstate = state;
    load   = 1'b0;
    res_nx = ss_res;
    hi_nx  = '0;
    f_op   = op;
    f_exop = exop;
    f_a    = srcA;
    f_b    = srcB;
    f_sh   = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        if (shift_go) nstate = SHIFT;
`ifdef ALU_MUL_EN
        else if (op == ALU_MUL) nstate = MUL;
`endif
        else begin
          nstate = DONE;
          load   = 1'b1;
        end
      end
      SHIFT: begin
        {f_op, f_exop, f_a, f_b} = {op_r, exop_r, a_r, b_r};
        res_nx = step_val;
        f_sh   = step_bit;
        if (cnt == CW'(1)) begin
          nstate = DONE;
          load   = 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        {f_op, f_exop, f_a, f_b} = {op_r, exop_r, a_r, b_r};
        res_nx = acc_nx[WIDTH-1:0];
        hi_nx  = acc_nx[2*WIDTH-1:WIDTH];
        if (cnt == CW'(1)) begin
          nstate = DONE;
          load   = 1'b1;
        end
      end
`endif
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  alu_flags #(.WIDTH(WIDTH)) u_flags (
    .op(f_op), .exop(f_exop), .a(f_a), .b(f_b),
    .result(res_nx), .result_hi(hi_nx), .shout(f_sh), .flags(flags_nx)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Operand latch, iteration counter, shifter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r    <= ALU_CPY;
      exop_r  <= AEX_SHFL;
      a_r     <= '0;
      b_r     <= '0;
      sh_r    <= '0;
      cnt     <= '0;
      res_r   <= '0;
      flags_r <= '0;
    end else begin
      if (accept) begin
        op_r   <= op;
        exop_r <= exop;
        a_r    <= srcA;
        b_r    <= srcB;
        sh_r   <= srcA;
        cnt    <= shift_go ? CW'(k) : CW'(WIDTH);
      end else if (state == SHIFT || state == MUL) begin
        sh_r <= step_val;
        cnt  <= cnt - CW'(1);
      end
      if (load) begin
        res_r   <= res_nx;
        flags_r <= flags_nx;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); MUL vectors follow ALU_MUL_EN.
module tb_alu_seq;
  import project_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  e_alu_op     op = ALU_CPY;
  e_alu_ext_op exop = AEX_SHFL;
  logic [7:0]  srcA = '0, srcB = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, zero, carry, negative, overflow;
  logic [7:0]  result, result_hi;

  int vectors = 0;
  int errs    = 0;
  int lat;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .op(op), .exop(exop), .srcA(srcA), .srcB(srcB),
    .in_valid(in_valid), .in_ready(in_ready), .result(result), .result_hi(result_hi),
    .zero(zero), .carry(carry), .negative(negative), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {zero, carry, negative, overflow}.
  task automatic chkf(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, zero, carry, negative, overflow}, {28'd0, exp});
  endtask

  // Present one op for a single edge; returns #1 after the accept edge.
  task automatic issue(input e_alu_op o, input e_alu_ext_op x, input logic [7:0] a, input logic [7:0] b);
    op = o; exop = x; srcA = a; srcB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    srcA = 8'hA5; srcB = 8'h5A;   // later input changes must not matter
  endtask

  // Cycles from the accept edge until out_valid is seen, bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst result_hi", result_hi, 0);
    chkf("rst flags", 4'b0000);
    rst = 1'b0;

    issue(ALU_ADD, AEX_SHFL, 8'd200, 8'd100);
    wait_done(lat);
    chk("add lat", lat, 1);
    chk("add res", result, 44);
    chkf("add flags", 4'b0100);
    chk("add in_ready", in_ready, 0);
    take();
    chk("add in_ready back", in_ready, 1);

    issue(ALU_SUB, AEX_SHFL, 8'd100, 8'd120);
    wait_done(lat);
    chk("sub1 res", result, 236);
    chkf("sub1 flags", 4'b0110);
    take();

    issue(ALU_SUB, AEX_SHFL, 8'd127, 8'd255);
    wait_done(lat);
    chk("sub2 res", result, 128);
    chkf("sub2 flags", 4'b0111);
    take();

    issue(ALU_EXT, AEX_SHFL, 8'h96, 8'd3);
    wait_done(lat);
    chk("shfl lat", lat, 4);
    chk("shfl res", result, 8'hB0);
    chkf("shfl flags", 4'b0010);
    take();

    issue(ALU_EXT, AEX_ASHR, 8'h80, 8'd7);
    wait_done(lat);
    chk("ashr lat", lat, 8);
    chk("ashr res", result, 8'hFF);
    chkf("ashr flags", 4'b0010);
    take();

    issue(ALU_EXT, AEX_ROTR, 8'h01, 8'd1);
    wait_done(lat);
    chk("rotr lat", lat, 2);
    chk("rotr res", result, 8'h80);
    chkf("rotr flags", 4'b0110);
    take();

    issue(ALU_EXT, AEX_SHFR, 8'h81, 8'd0);
    wait_done(lat);
    chk("ext k0 lat", lat, 1);
    chk("ext k0 res", result, 8'h81);
    chkf("ext k0 flags", 4'b0010);
    take();

    issue(ALU_GT, AEX_SHFL, 8'd5, 8'd3);
    wait_done(lat);
    chk("gt res", result, 1);
    take();

    issue(ALU_XOR, AEX_SHFL, 8'hF0, 8'hFF);
    wait_done(lat);
    chk("xor res", result, 8'h0F);
    take();

    issue(e_alu_op'(4'd12), AEX_SHFL, 8'h33, 8'h44);
    wait_done(lat);
    chk("bad op res", result, 0);
    chkf("bad op flags", 4'b1000);
    take();

`ifdef ALU_MUL_EN
    issue(ALU_MUL, AEX_SHFL, 8'd200, 8'd3);
    wait_done(lat);
    chk("mul1 lat", lat, 9);
    chk("mul1 lo", result, 8'h58);
    chk("mul1 hi", result_hi, 8'h02);
    chkf("mul1 flags", 4'b0100);
    take();

    issue(ALU_MUL, AEX_SHFL, 8'd15, 8'd17);
    wait_done(lat);
    chk("mul2 lo", result, 8'hFF);
    chk("mul2 hi", result_hi, 8'h00);
    chkf("mul2 flags", 4'b0010);
    take();
`else
    issue(ALU_MUL, AEX_SHFL, 8'd200, 8'd3);
    wait_done(lat);
    chk("mul off lat", lat, 1);
    chk("mul off lo", result, 0);
    chk("mul off hi", result_hi, 0);
    chkf("mul off flags", 4'b1000);
    take();
`endif

    // Backpressure: result held, new request ignored while DONE.
    issue(ALU_ADD, AEX_SHFL, 8'd1, 8'd2);
    wait_done(lat);
    op = ALU_CPY; srcA = 8'h55; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid", out_valid, 1);
      chk("bp result", result, 3);
      chk("bp in_ready", in_ready, 0);
    end
    take();
    chk("bp release in_ready", in_ready, 1);
    chk("bp no same-cycle accept", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp next accepted", out_valid, 1);
    chk("bp next result", result, 8'h55);
    take();

    // Abort mid-operation with an asynchronous reset.
`ifdef ALU_MUL_EN
    issue(ALU_MUL, AEX_SHFL, 8'd200, 8'd3);
`else
    issue(ALU_EXT, AEX_SHFL, 8'h96, 8'd7);
`endif
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort in_ready", in_ready, 1);
    chk("abort out_valid", out_valid, 0);
    chk("abort result", result, 0);
    chk("abort result_hi", result_hi, 0);
    chkf("abort flags", 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(ALU_ADD, AEX_SHFL, 8'd1, 8'd1);
    wait_done(lat);
    chk("post-reset add lat", lat, 1);
    chk("post-reset add res", result, 2);
    take();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
